// File: rtl/mlp_pkg.sv
// mlp_pkg: shared FSM state type, default layer sizes and width helper for the MLP sequencer
package mlp_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, MAC, WRITE, DONE} state_e;

    function automatic int clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Reset-time neuron count per layer; layers beyond the fourth default to 1
    function automatic int default_count(input int i);
        return (i == 0) ? 4 : (i == 1 || i == 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/mlp_sequencer_if.sv
// mlp_sequencer_if: configuration/control inputs and MAC datapath strobes of the sequencer
interface mlp_sequencer_if #(
    parameter int LAYER_W  = 2,
    parameter int NEURON_W = 8,
    parameter int WADDR_W  = 16
);
    logic                        cfg_we;
    logic [LAYER_W-1:0]          cfg_layer;
    logic [NEURON_W-1:0]         cfg_count;
    logic                        start;
    logic                        abort;
    logic [LAYER_W+NEURON_W-1:0] in_neuron_addr;
    logic [LAYER_W+NEURON_W-1:0] out_neuron_addr;
    logic [WADDR_W-1:0]          weight_addr;
    logic                        mac_clear;
    logic                        mac_en;
    logic                        write_neuron;
    logic                        relu_en;
    logic                        busy;
    logic                        done;
    logic                        cfg_err;

    modport master (
        output cfg_we, cfg_layer, cfg_count, start, abort,
        input  in_neuron_addr, out_neuron_addr, weight_addr, mac_clear, mac_en,
               write_neuron, relu_en, busy, done, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_layer, cfg_count, start, abort,
        output in_neuron_addr, out_neuron_addr, weight_addr, mac_clear, mac_en,
               write_neuron, relu_en, busy, done, cfg_err
    );
endinterface

// File: rtl/mlp_layer_table.sv
// mlp_layer_table: per-layer neuron-count register file, one write port and two read ports
module mlp_layer_table
    import mlp_pkg::*;
#(
    parameter int LAYERS   = 4,
    parameter int NEURON_W = 8,
    parameter int LAYER_W  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [LAYER_W-1:0]  wsel,
    input  logic [NEURON_W-1:0] wdata,
    input  logic [LAYER_W-1:0]  rsel_a,
    input  logic [LAYER_W-1:0]  rsel_b,
    output logic [NEURON_W-1:0] rdata_a,
    output logic [NEURON_W-1:0] rdata_b,
    output logic                all_nonzero
);
    logic [NEURON_W-1:0] cnt_q [LAYERS];
    logic [NEURON_W-1:0] cnt_d [LAYERS];

    always_comb begin
        cnt_d = cnt_q;
        if (we && 32'(wsel) < LAYERS) cnt_d[wsel] = wdata;
    end

    always_comb begin
        all_nonzero = 1'b1;
        for (int i = 0; i < LAYERS; i++) if (cnt_q[i] == '0) all_nonzero = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) for (int i = 0; i < LAYERS; i++) cnt_q[i] <= NEURON_W'(default_count(i));
        else cnt_q <= cnt_d;
    end

    assign rdata_a = cnt_q[rsel_a];
    assign rdata_b = cnt_q[rsel_b];
endmodule

// File: rtl/mlp_sequencer.sv
// mlp_sequencer: walks every layer/neuron/input of an MLP forward pass, driving MAC
// strobes and neuron/weight addresses from registered state only
module mlp_sequencer
    import mlp_pkg::*;
#(
    parameter int  LAYERS   = 4,
    parameter int  NEURON_W = 8,
    parameter int  WADDR_W  = 16,
    localparam int LAYER_W  = clog2(LAYERS)
) (
    input logic            clk,
    input logic            reset,
    mlp_sequencer_if.slave bus
);
    localparam logic [LAYER_W-1:0] LAST = LAYER_W'(LAYERS - 2);

    state_e                      state_q, state_d;
    logic [LAYER_W-1:0]          layer_q, layer_d;
    logic [NEURON_W-1:0]         neuron_q, neuron_d, j_q, j_d, cnt_cur, cnt_nxt;
    logic [WADDR_W-1:0]          waddr_q, waddr_d;
    logic [LAYER_W+NEURON_W-1:0] in_addr_q, in_addr_d, out_addr_q, out_addr_d;
    logic mac_clear_q, mac_clear_d, mac_en_q, mac_en_d, write_q, write_d;
    logic relu_q, relu_d, busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
    logic table_ok;

    mlp_layer_table #(.LAYERS(LAYERS), .NEURON_W(NEURON_W), .LAYER_W(LAYER_W)) u_table (
        .clk         (clk),
        .reset       (reset),
        .we          (bus.cfg_we && state_q == IDLE),
        .wsel        (bus.cfg_layer),
        .wdata       (bus.cfg_count),
        .rsel_a      (layer_q),
        .rsel_b      (layer_q + 1'b1),
        .rdata_a     (cnt_cur),
        .rdata_b     (cnt_nxt),
        .all_nonzero (table_ok)
    );

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        neuron_d  = neuron_q;
        j_d       = j_q;
        waddr_d   = waddr_q;
        cfg_err_d = 1'b0;
        if (bus.abort) state_d = IDLE;
        else case (state_q)
            IDLE: begin
                cfg_err_d = bus.start && !table_ok;
                if (bus.start && table_ok) begin
                    state_d  = CLEAR;
                    layer_d  = '0;
                    neuron_d = '0;
                    j_d      = '0;
                    waddr_d  = '0;
                end
            end
            CLEAR: state_d = MAC;
            MAC: begin
                j_d     = j_q + 1'b1;
                waddr_d = waddr_q + 1'b1;
                if (j_q == cnt_cur - 1'b1) state_d = WRITE;
            end
            WRITE: begin
                j_d = '0;
                if (neuron_q < cnt_nxt - 1'b1) begin
                    neuron_d = neuron_q + 1'b1;
                    state_d  = CLEAR;
                end else if (layer_q != LAST) begin
                    layer_d  = layer_q + 1'b1;
                    neuron_d = '0;
                    state_d  = CLEAR;
                end else state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so they register in step with it
        busy_d      = state_d inside {CLEAR, MAC, WRITE};
        mac_clear_d = state_d == CLEAR;
        mac_en_d    = state_d == MAC;
        write_d     = state_d == WRITE;
        relu_d      = write_d && layer_d != LAST;
        done_d      = state_d == DONE;
        in_addr_d   = busy_d ? {layer_d, j_d} : '0;
        out_addr_d  = busy_d ? {layer_d + 1'b1, neuron_d} : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            layer_q     <= '0;
            neuron_q    <= '0;
            j_q         <= '0;
            waddr_q     <= '0;
            in_addr_q   <= '0;
            out_addr_q  <= '0;
            mac_clear_q <= 1'b0;
            mac_en_q    <= 1'b0;
            write_q     <= 1'b0;
            relu_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            neuron_q    <= neuron_d;
            j_q         <= j_d;
            waddr_q     <= waddr_d;
            in_addr_q   <= in_addr_d;
            out_addr_q  <= out_addr_d;
            mac_clear_q <= mac_clear_d;
            mac_en_q    <= mac_en_d;
            write_q     <= write_d;
            relu_q      <= relu_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign bus.in_neuron_addr  = in_addr_q;
    assign bus.out_neuron_addr = out_addr_q;
    assign bus.weight_addr     = waddr_q;
    assign bus.mac_clear       = mac_clear_q;
    assign bus.mac_en          = mac_en_q;
    assign bus.write_neuron    = write_q;
    assign bus.relu_en         = relu_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.cfg_err         = cfg_err_q;
endmodule

// File: tb/tb_mlp_sequencer.sv
// tb_mlp_sequencer: directed checks of the default 4-layer sequencer and a 2-layer variant
module tb_mlp_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mlp_sequencer_if #(.LAYER_W(2), .NEURON_W(8), .WADDR_W(16)) bus_a ();
    mlp_sequencer_if #(.LAYER_W(1), .NEURON_W(8), .WADDR_W(2)) bus_b ();

    mlp_sequencer #(.LAYERS(4), .NEURON_W(8), .WADDR_W(16)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    mlp_sequencer #(.LAYERS(2), .NEURON_W(8), .WADDR_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, 32'(bus_a.busy), 0);
        chk({tag, " done"}, 32'(bus_a.done), 0);
        chk({tag, " mac_clear"}, 32'(bus_a.mac_clear), 0);
        chk({tag, " mac_en"}, 32'(bus_a.mac_en), 0);
        chk({tag, " write"}, 32'(bus_a.write_neuron), 0);
        chk({tag, " relu"}, 32'(bus_a.relu_en), 0);
        chk({tag, " cfg_err"}, 32'(bus_a.cfg_err), 0);
        chk({tag, " waddr"}, 32'(bus_a.weight_addr), 0);
        chk({tag, " in_addr"}, 32'(bus_a.in_neuron_addr), 0);
        chk({tag, " out_addr"}, 32'(bus_a.out_neuron_addr), 0);
    endtask

    // Full default-table pass: 24 busy cycles, 14 MACs, 5 writes, done 25 cycles after start
    task automatic run_pass(input string tag, input bit hold);
        logic [31:0] exp_in [14] = '{0, 1, 2, 3, 0, 1, 2, 3, 256, 257, 256, 257, 512, 513};
        logic [31:0] exp_out [5] = '{256, 257, 512, 513, 768};
        logic [31:0] exp_relu [5] = '{1, 1, 1, 1, 0};
        int macs = 0, writes = 0, busy_n = 0, done_k = 0, done_n = 0;
        bus_a.start = 1'b1;
        step;
        if (!hold) bus_a.start = 1'b0;
        chk({tag, " first clear"}, 32'(bus_a.mac_clear), 1);
        for (int k = 1; k <= 26; k++) begin
            if (k > 1) step;
            if (bus_a.busy) busy_n++;
            if (bus_a.mac_en) begin
                if (macs < 14) begin
                    chk({tag, " mac waddr"}, 32'(bus_a.weight_addr), 32'(macs));
                    chk({tag, " mac in_addr"}, 32'(bus_a.in_neuron_addr), exp_in[macs]);
                end
                macs++;
            end
            if (bus_a.write_neuron) begin
                if (writes < 5) begin
                    chk({tag, " write out_addr"}, 32'(bus_a.out_neuron_addr), exp_out[writes]);
                    chk({tag, " write relu"}, 32'(bus_a.relu_en), exp_relu[writes]);
                end
                writes++;
            end
            if (bus_a.done) begin
                done_n++;
                if (done_k == 0) begin
                    done_k = k;
                    chk({tag, " done waddr"}, 32'(bus_a.weight_addr), 14);
                end
            end
        end
        chk({tag, " mac count"}, 32'(macs), 14);
        chk({tag, " write count"}, 32'(writes), 5);
        chk({tag, " busy cycles"}, 32'(busy_n), 24);
        chk({tag, " done cycle"}, 32'(done_k), 25);
        chk({tag, " done pulses"}, 32'(done_n), 1);
        if (hold) begin
            step;
            chk({tag, " restart clear"}, 32'(bus_a.mac_clear), 1);
            bus_a.start = 1'b0;
            bus_a.abort = 1'b1;
            step;
            bus_a.abort = 1'b0;
            chk({tag, " restart aborted"}, 32'(bus_a.busy), 0);
        end
    endtask

    initial begin
        int dn;
        int busy_n, done_k, macs, writes;
        bus_a.cfg_we = 1'b0; bus_a.cfg_layer = '0; bus_a.cfg_count = '0;
        bus_a.start = 1'b0; bus_a.abort = 1'b0;
        bus_b.cfg_we = 1'b0; bus_b.cfg_layer = '0; bus_b.cfg_count = '0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0;
        step;
        step;
        chk_zero("reset");
        reset = 1'b0;
        step;

        run_pass("pass1", 1'b0);

        // Zero count in layer 1 blocks start
        bus_a.cfg_we = 1'b1; bus_a.cfg_layer = 2'd1; bus_a.cfg_count = 8'd0;
        step;
        bus_a.cfg_we = 1'b0; bus_a.start = 1'b1;
        step;
        bus_a.start = 1'b0;
        chk("reject cfg_err", 32'(bus_a.cfg_err), 1);
        chk("reject busy", 32'(bus_a.busy), 0);
        step;
        chk("reject cfg_err pulse", 32'(bus_a.cfg_err), 0);
        chk("reject busy after", 32'(bus_a.busy), 0);

        // Same-cycle repair and start: the check sees the old zero entry
        bus_a.cfg_we = 1'b1; bus_a.cfg_layer = 2'd1; bus_a.cfg_count = 8'd2; bus_a.start = 1'b1;
        step;
        bus_a.cfg_we = 1'b0; bus_a.start = 1'b0;
        chk("same-cycle cfg_err", 32'(bus_a.cfg_err), 1);
        chk("same-cycle busy", 32'(bus_a.busy), 0);
        step;
        run_pass("pass2", 1'b0);

        // Abort in the third MAC cycle
        bus_a.start = 1'b1;
        step;
        bus_a.start = 1'b0;
        step;
        step;
        step;
        chk("abort mac3 en", 32'(bus_a.mac_en), 1);
        chk("abort mac3 waddr", 32'(bus_a.weight_addr), 2);
        bus_a.abort = 1'b1;
        step;
        bus_a.abort = 1'b0;
        chk("abort busy", 32'(bus_a.busy), 0);
        chk("abort mac_en", 32'(bus_a.mac_en), 0);
        chk("abort done", 32'(bus_a.done), 0);
        dn = 0;
        for (int k = 0; k < 30; k++) begin
            step;
            if (bus_a.done || bus_a.busy) dn++;
        end
        chk("abort stays idle", 32'(dn), 0);
        run_pass("pass3", 1'b0);

        // Reset during the write of neuron 1; the altered layer 3 entry must revert
        bus_a.cfg_we = 1'b1; bus_a.cfg_layer = 2'd3; bus_a.cfg_count = 8'd3;
        step;
        bus_a.cfg_we = 1'b0; bus_a.start = 1'b1;
        step;
        bus_a.start = 1'b0;
        for (int k = 2; k <= 12; k++) step;
        chk("midreset write", 32'(bus_a.write_neuron), 1);
        chk("midreset out_addr", 32'(bus_a.out_neuron_addr), 257);
        reset = 1'b1;
        step;
        reset = 1'b0;
        chk_zero("midreset");
        step;
        run_pass("pass4", 1'b0);

        run_pass("hold", 1'b1);
        step;

        // Two-layer variant with counts 3,1 and a 2-bit weight address
        bus_b.cfg_we = 1'b1; bus_b.cfg_layer = 1'b0; bus_b.cfg_count = 8'd3;
        step;
        bus_b.cfg_layer = 1'b1; bus_b.cfg_count = 8'd1;
        step;
        bus_b.cfg_we = 1'b0; bus_b.start = 1'b1;
        step;
        bus_b.start = 1'b0;
        chk("l2 first clear", 32'(bus_b.mac_clear), 1);
        busy_n = 0; done_k = 0; macs = 0; writes = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) step;
            if (bus_b.busy) busy_n++;
            if (bus_b.mac_en) begin
                chk("l2 mac waddr", 32'(bus_b.weight_addr), 32'(macs));
                chk("l2 mac in_addr", 32'(bus_b.in_neuron_addr), 32'(macs));
                macs++;
            end
            if (bus_b.write_neuron) begin
                chk("l2 write relu", 32'(bus_b.relu_en), 0);
                chk("l2 write out_addr", 32'(bus_b.out_neuron_addr), 256);
                writes++;
            end
            if (bus_b.done && done_k == 0) begin
                done_k = k;
                chk("l2 done waddr", 32'(bus_b.weight_addr), 3);
            end
        end
        chk("l2 mac count", 32'(macs), 3);
        chk("l2 write count", 32'(writes), 1);
        chk("l2 busy cycles", 32'(busy_n), 5);
        chk("l2 done cycle", 32'(done_k), 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
